// File: rtl/merge_pkg.sv
// merge_pkg: definitions shared by the merge-stage blocks.
//   DATA_W   - default word width, shared with fifoMerge
//   ptr_w()  - bit width of a read/write pointer for a given depth
//   lvl_w()  - bit width of an occupancy count 0..depth, i.e. clog2(depth+1)
package merge_pkg;

  localparam int DATA_W = 8;

  // A pointer only has to address entries 0..depth-1, but it must be at
  // least one bit wide, even when depth is small.
  function automatic int ptr_w(input int depth);
    return (depth <= 2) ? 1 : $clog2(depth);
  endfunction

  // Level has to represent the full value depth, hence depth+1 codes.
  function automatic int lvl_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/merge_fifo_ram.sv
// merge_fifo_ram: storage array for merge_fifo.
//   clock - write clock (rising edge)
//   we    - write enable; wdata is stored at waddr on the edge
//   waddr - write address, 0..depth-1
//   wdata - write data
//   raddr - read address (combinational read port)
//   rdata - word currently stored at raddr
// The array has no reset; stale contents are hidden by the owner's level
// bookkeeping.
module merge_fifo_ram
  import merge_pkg::*;
#(
  parameter int width = DATA_W,
  parameter int depth = 4,
  parameter int aw    = ptr_w(depth)
) (
  input  logic             clock,
  input  logic             we,
  input  logic [aw-1:0]    waddr,
  input  logic [width-1:0] wdata,
  input  logic [aw-1:0]    raddr,
  output logic [width-1:0] rdata
);

  logic [width-1:0] mem [depth];

  always_ff @(posedge clock) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/merge_fifo.sv
// merge_fifo: first-word-fall-through synchronous FIFO between merge stages.
//   clock     - sole clock, rising edge
//   reset     - asynchronous, active-high reset
//   push_n    - active-low write strobe
//   dataIn    - write data, stored on the edge when the push is accepted
//   pop_n     - active-low read strobe
//   dataOut   - head word, shown combinationally; zero while empty
//   full      - level == depth
//   empty     - level == 0
//   level     - occupancy, 0..depth
//   overflow  - sticky, a push was rejected (cleared only by reset)
//   underflow - sticky, a pop was rejected (cleared only by reset)
//
// Strobe handshake: each strobe is a request sampled on the rising edge.
// A pop is accepted when the FIFO holds a word. A push is accepted when
// there is room, or when a pop is accepted on the same edge (the freed slot
// is reused). An accepted request takes effect on that edge. A request
// that is not accepted changes no data and sets its sticky flag. There is
// no back-pressure wait: the producer sees full/empty and the sticky flags.
module merge_fifo
  import merge_pkg::*;
#(
  parameter int width = DATA_W,
  parameter int depth = 4
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       push_n,
  input  logic [width-1:0]           dataIn,
  input  logic                       pop_n,
  output logic [width-1:0]           dataOut,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(depth+1)-1:0] level,
  output logic                       overflow,
  output logic                       underflow
);

  localparam int PW = ptr_w(depth);
  localparam int LW = lvl_w(depth);

  typedef logic [PW-1:0] ptr_t;
  typedef logic [LW-1:0] lvl_t;

  ptr_t             wr_ptr;
  ptr_t             rd_ptr;
  lvl_t             lvl_q;
  logic             push_ok;
  logic             pop_ok;
  logic [width-1:0] rd_data;

  // Depth need not be a power of two, so the wrap is an explicit compare
  // rather than relying on pointer overflow.
  function automatic ptr_t ptr_inc(input ptr_t p);
    return (p == ptr_t'(depth - 1)) ? '0 : p + ptr_t'(1);
  endfunction

  // Status is decoded from the registered level only.
  assign empty = (lvl_q == '0);
  assign full  = (lvl_q == lvl_t'(depth));
  assign level = lvl_q;

  // A pop on an empty FIFO never succeeds, even alongside a push.
  // A push on a full FIFO succeeds only if a pop frees the head slot.
  assign pop_ok  = !pop_n && !empty;
  assign push_ok = !push_n && (!full || pop_ok);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      lvl_q     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (push_ok) begin
        wr_ptr <= ptr_inc(wr_ptr);
      end
      if (pop_ok) begin
        rd_ptr <= ptr_inc(rd_ptr);
      end
      case ({push_ok, pop_ok})
        2'b10:   lvl_q <= lvl_q + lvl_t'(1);
        2'b01:   lvl_q <= lvl_q - lvl_t'(1);
        default: lvl_q <= lvl_q;
      endcase
      if (!push_n && !push_ok) begin
        overflow <= 1'b1;
      end
      if (!pop_n && !pop_ok) begin
        underflow <= 1'b1;
      end
    end
  end

  merge_fifo_ram #(
    .width (width),
    .depth (depth),
    .aw    (PW)
  ) u_ram (
    .clock (clock),
    .we    (push_ok),
    .waddr (wr_ptr),
    .wdata (dataIn),
    .raddr (rd_ptr),
    .rdata (rd_data)
  );

  // The array is not reset, so the head is masked to zero while empty.
  assign dataOut = empty ? '0 : rd_data;

endmodule

// File: tb/tb_merge_fifo.sv
// tb_merge_fifo: three merge_fifo instances (depth 4, 3 and 5) share one
// stimulus stream. A queue model per instance predicts every output after
// each edge; literal checks on the depth-4 instance pin the model.
module tb_merge_fifo;

  // ---------------- clock / reset ----------------
  logic clock;
  logic reset;
  logic push_n;
  logic pop_n;
  logic [7:0] dataIn;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // ---------------- DUTs ----------------
  logic [7:0] dout4, dout3, dout5;
  logic       full4, full3, full5;
  logic       empty4, empty3, empty5;
  logic [2:0] lvl4;
  logic [1:0] lvl3;
  logic [2:0] lvl5;
  logic       ovf4, ovf3, ovf5;
  logic       unf4, unf3, unf5;

  merge_fifo #(.width(8), .depth(4)) dut4 (
    .clock(clock), .reset(reset), .push_n(push_n), .dataIn(dataIn),
    .pop_n(pop_n), .dataOut(dout4), .full(full4), .empty(empty4),
    .level(lvl4), .overflow(ovf4), .underflow(unf4)
  );

  merge_fifo #(.width(8), .depth(3)) dut3 (
    .clock(clock), .reset(reset), .push_n(push_n), .dataIn(dataIn),
    .pop_n(pop_n), .dataOut(dout3), .full(full3), .empty(empty3),
    .level(lvl3), .overflow(ovf3), .underflow(unf3)
  );

  merge_fifo #(.width(8), .depth(5)) dut5 (
    .clock(clock), .reset(reset), .push_n(push_n), .dataIn(dataIn),
    .pop_n(pop_n), .dataOut(dout5), .full(full5), .empty(empty5),
    .level(lvl5), .overflow(ovf5), .underflow(unf5)
  );

  // ---------------- scoreboard ----------------
  int         n_cmp = 0;
  int         n_err = 0;
  int         dep [3] = '{4, 3, 5};
  logic [7:0] exp_q [3][$];
  logic       exp_ovf [3];
  logic       exp_unf [3];

  initial begin
    for (int i = 0; i < 3; i++) begin
      exp_ovf[i] = 1'b0;
      exp_unf[i] = 1'b0;
    end
  end

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 3; i++) begin
      exp_q[i].delete();
      exp_ovf[i] = 1'b0;
      exp_unf[i] = 1'b0;
    end
  endtask

  // One rising edge of an ideal bounded queue.
  task automatic model_step();
    if (reset) begin
      model_clear();
    end else begin
      for (int i = 0; i < 3; i++) begin
        bit pop_acc;
        bit push_acc;
        pop_acc  = !pop_n && (exp_q[i].size() > 0);
        push_acc = !push_n && ((exp_q[i].size() < dep[i]) || pop_acc);
        if (!pop_n && !pop_acc) exp_unf[i] = 1'b1;
        if (!push_n && !push_acc) exp_ovf[i] = 1'b1;
        if (pop_acc) void'(exp_q[i].pop_front());
        if (push_acc) exp_q[i].push_back(dataIn);
      end
    end
  endtask

  task automatic check_inst(input int i, input logic [7:0] d, input int l,
                            input logic f, input logic e, input logic o,
                            input logic u);
    int         n;
    logic [7:0] head;
    n    = exp_q[i].size();
    head = (n > 0) ? exp_q[i][0] : 8'h00;
    chk($sformatf("d%0d.level", dep[i]), l, n);
    chk($sformatf("d%0d.full", dep[i]), f, (n == dep[i]));
    chk($sformatf("d%0d.empty", dep[i]), e, (n == 0));
    chk($sformatf("d%0d.dataOut", dep[i]), d, head);
    chk($sformatf("d%0d.overflow", dep[i]), o, exp_ovf[i]);
    chk($sformatf("d%0d.underflow", dep[i]), u, exp_unf[i]);
  endtask

  task automatic check_all();
    check_inst(0, dout4, int'(lvl4), full4, empty4, ovf4, unf4);
    check_inst(1, dout3, int'(lvl3), full3, empty3, ovf3, unf3);
    check_inst(2, dout5, int'(lvl5), full5, empty5, ovf5, unf5);
  endtask

  // Compare process: every edge, advance the model then check all outputs.
  always @(posedge clock) begin
    model_step();
    #1;
    check_all();
  end

  // ---------------- driver tasks ----------------
  // Apply one edge's worth of strobes; return 2 time units after the edge
  // with strobes back to idle.
  task automatic drive(input logic pn, input logic [7:0] d, input logic qn);
    @(negedge clock);
    push_n = pn;
    dataIn = d;
    pop_n  = qn;
    @(posedge clock);
    #2;
    push_n = 1'b1;
    pop_n  = 1'b1;
  endtask

  task automatic push(input logic [7:0] d);
    drive(1'b0, d, 1'b1);
  endtask

  task automatic pop();
    drive(1'b1, 8'h00, 1'b0);
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    logic [7:0] vals [4];
    vals = '{8'h05, 8'h01, 8'h09, 8'h03};
    reset  = 1'b1;
    push_n = 1'b1;
    pop_n  = 1'b1;
    dataIn = 8'h00;

    // Reset state.
    #2;
    chk("rst.empty", empty4, 1'b1);
    chk("rst.full", full4, 1'b0);
    chk("rst.dataOut", dout4, 8'h00);
    chk("rst.level", lvl4, 3'd0);
    chk("rst.flags", {ovf4, unf4}, 2'b00);
    do_reset();

    // Fill depth 4, then drain in order.
    for (int i = 0; i < 4; i++) push(vals[i]);
    chk("fill.full", full4, 1'b1);
    chk("fill.level", lvl4, 3'd4);

    // Push onto full without a pop.
    push(8'hAA);
    chk("ovf.flag", ovf4, 1'b1);
    chk("ovf.level", lvl4, 3'd4);
    chk("ovf.head", dout4, 8'h05);

    for (int i = 0; i < 4; i++) begin
      chk($sformatf("drain.word%0d", i), dout4, vals[i]);
      pop();
    end
    chk("drain.empty", empty4, 1'b1);
    chk("drain.dataOut", dout4, 8'h00);

    // Pop on empty.
    do_reset();
    pop();
    chk("unf.flag", unf4, 1'b1);
    chk("unf.level", lvl4, 3'd0);

    // Simultaneous push and pop on empty: push lands, pop is rejected.
    do_reset();
    drive(1'b0, 8'h42, 1'b0);
    chk("pp_empty.level", lvl4, 3'd1);
    chk("pp_empty.dataOut", dout4, 8'h42);
    chk("pp_empty.underflow", unf4, 1'b1);

    // Simultaneous push and pop on full: level holds, 0x77 comes out last.
    do_reset();
    for (int i = 1; i <= 4; i++) push(8'(i * 16));
    drive(1'b0, 8'h77, 1'b0);
    chk("pp_full.level", lvl4, 3'd4);
    chk("pp_full.head", dout4, 8'h20);
    for (int i = 0; i < 3; i++) pop();
    chk("pp_full.last", dout4, 8'h77);
    pop();
    chk("pp_full.empty", empty4, 1'b1);

    // Pointer wrap: fill each depth, then 10 paired push/pop edges.
    do_reset();
    for (int i = 0; i < 5; i++) push(8'h30 + 8'(i));
    for (int i = 0; i < 10; i++) drive(1'b0, 8'hC0 + 8'(i), 1'b0);
    // depth 4 now holds the last four pushed words: C6..C9.
    chk("wrap.head", dout4, 8'hC6);
    for (int i = 0; i < 6; i++) pop();
    chk("wrap.empty", empty4, 1'b1);

    // Asynchronous reset with 3 words stored.
    do_reset();
    for (int i = 0; i < 3; i++) push(8'h50 + 8'(i));
    #1;
    reset = 1'b1;
    #1;
    model_clear();
    chk("async.empty", empty4, 1'b1);
    chk("async.dataOut", dout4, 8'h00);
    chk("async.level", lvl4, 3'd0);
    @(negedge clock);
    reset = 1'b0;
    push(8'h11);
    chk("post_rst.head", dout4, 8'h11);
    pop();
    chk("post_rst.empty", empty4, 1'b1);

    @(negedge clock);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
